// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types, constants and popcount helper for the register file
package rf_pkg;

    localparam int RF_ADDR      = 5;
    localparam int RF_MAX_ENTRY = 256;

    typedef logic [RF_ADDR-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

    // Fixed-width popcount; callers zero-extend their busy vector into it.
    function automatic int unsigned popcount(input logic [RF_MAX_ENTRY-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < RF_MAX_ENTRY; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_wr_merge.sv
// rtl/rf_wr_merge.sv - per-entry write-port priority resolve (enable, port select, busy clear)
module rf_wr_merge
    import rf_pkg::*;
#(
    parameter int ADDR    = RF_ADDR,
    parameter int NWR     = 1,
    parameter int ZERO_R0 = 1,
    parameter int NENTRY  = 2 ** ADDR,
    parameter int SELW    = (NWR > 1) ? $clog2(NWR) : 1
) (
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*ADDR-1:0]    wr_rd,
    input  logic [NWR-1:0]         wr_clr,
    output logic [NENTRY-1:0]      we,
    output logic [NENTRY*SELW-1:0] wsel,
    output logic [NENTRY-1:0]      clr
);

    always_comb begin
        we   = '0;
        wsel = '0;
        clr  = '0;
        for (int e = 0; e < NENTRY; e++) begin
            // Ascending scan: a later (higher-index) port overrides earlier ones.
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_rd[j*ADDR +: ADDR] == ADDR'(e))) begin
                    we[e]                = 1'b1;
                    wsel[e*SELW +: SELW] = SELW'(j);
                    clr[e]               = wr_clr[j];
                end
            end
            if ((ZERO_R0 != 0) && (ADDR'(e) == ADDR'(ZERO_REG))) begin
                we[e]                = 1'b0;
                wsel[e*SELW +: SELW] = '0;
                clr[e]               = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port integer register file with bypass and busy scoreboard
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ADDR    = RF_ADDR,
    parameter int NRD     = 2,
    parameter int NWR     = 1,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NRD*ADDR-1:0]   rs,
    output logic [NRD*WIDTH-1:0]  rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR-1:0]   wr_rd,
    input  logic [NWR*WIDTH-1:0]  wdata,
    input  logic [NWR-1:0]        wr_clr,
    input  logic                  iss_en,
    input  logic [ADDR-1:0]       iss_rd,
    output logic                  iss_stall,
    output logic [ADDR:0]         busy_cnt
);

    localparam int NENTRY = 2 ** ADDR;
    localparam int SELW   = (NWR > 1) ? $clog2(NWR) : 1;

    logic [NENTRY-1:0][WIDTH-1:0] data_q;
    logic [NENTRY-1:0]            busy_q;
    logic [NENTRY-1:0]            busy_nxt;
    logic [ADDR:0]                busy_cnt_q;

    logic [NENTRY-1:0]            we;
    logic [NENTRY*SELW-1:0]       wsel;
    logic [NENTRY-1:0]            clr;
    logic [NENTRY-1:0][WIDTH-1:0] wval;

    rf_wr_merge #(
        .ADDR    (ADDR),
        .NWR     (NWR),
        .ZERO_R0 (ZERO_R0),
        .NENTRY  (NENTRY),
        .SELW    (SELW)
    ) u_wr_merge (
        .wr_en  (wr_en),
        .wr_rd  (wr_rd),
        .wr_clr (wr_clr),
        .we     (we),
        .wsel   (wsel),
        .clr    (clr)
    );

    always_comb begin
        wval = '0;
        for (int e = 0; e < NENTRY; e++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wsel[e*SELW +: SELW] == SELW'(j)) begin
                    wval[e] = wdata[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Stall looks only at pre-edge busy, so a same-cycle release does not unblock issue.
    assign iss_stall = iss_en && busy_q[iss_rd];

    always_comb begin
        busy_nxt = busy_q;
        for (int e = 0; e < NENTRY; e++) begin
            if (clr[e]) begin
                busy_nxt[e] = 1'b0;
            end
            if (iss_en && !iss_stall && (iss_rd == ADDR'(e)) &&
                !((ZERO_R0 != 0) && (ADDR'(e) == ADDR'(ZERO_REG)))) begin
                busy_nxt[e] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int e = 0; e < NENTRY; e++) begin
                if (we[e]) begin
                    data_q[e] <= wval[e];
                end
            end
            busy_q     <= busy_nxt;
            busy_cnt_q <= (ADDR+1)'(popcount(RF_MAX_ENTRY'(busy_nxt)));
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [ADDR-1:0] ra;
        assign ra = rs[gi*ADDR +: ADDR];

        always_comb begin
            rdata[gi*WIDTH +: WIDTH] = data_q[ra];
            rbusy[gi]                = busy_q[ra];
            if ((BYPASS != 0) && we[ra]) begin
                rdata[gi*WIDTH +: WIDTH] = wval[ra];
                if (clr[ra]) begin
                    rbusy[gi] = 1'b0;
                end
            end
            if ((ZERO_R0 != 0) && (ra == ADDR'(ZERO_REG))) begin
                rdata[gi*WIDTH +: WIDTH] = '0;
                rbusy[gi]                = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed scoreboard bench for regfile_mp_sb (NWR=2, BYPASS=1)
module tb_regfile_mp_sb;

    localparam int WIDTH = 32;
    localparam int ADDR  = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                 clk;
    logic                 reset_n;
    logic [NRD*ADDR-1:0]  rs;
    logic [NRD*WIDTH-1:0] rdata;
    logic [NRD-1:0]       rbusy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*ADDR-1:0]  wr_rd;
    logic [NWR*WIDTH-1:0] wdata;
    logic [NWR-1:0]       wr_clr;
    logic                 iss_en;
    logic [ADDR-1:0]      iss_rd;
    logic                 iss_stall;
    logic [ADDR:0]        busy_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    regfile_mp_sb #(
        .WIDTH   (WIDTH),
        .ADDR    (ADDR),
        .NRD     (NRD),
        .NWR     (NWR),
        .BYPASS  (1),
        .ZERO_R0 (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rs        (rs),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .wdata     (wdata),
        .wr_clr    (wr_clr),
        .iss_en    (iss_en),
        .iss_rd    (iss_rd),
        .iss_stall (iss_stall),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic idle();
        wr_en  = '0;
        wr_rd  = '0;
        wdata  = '0;
        wr_clr = '0;
        iss_en = 1'b0;
        iss_rd = '0;
        rs     = '0;
    endtask

    task automatic wr0(input logic [4:0] rd, input logic [31:0] d, input logic c);
        wr_en[0]      = 1'b1;
        wr_rd[4:0]    = rd;
        wdata[31:0]   = d;
        wr_clr[0]     = c;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #1;
        push("rst_rdata0", 32'h0);   chk(rdata[31:0]);
        push("rst_rbusy", 32'h0);    chk(32'(rbusy));
        push("rst_cnt", 32'h0);      chk(32'(busy_cnt));
        @(negedge clk);
        reset_n = 1'b1;

        // Fill every register, then mark r4 busy.
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            idle();
            wr0(5'(r), 32'h100 + 32'(r), 1'b0);
        end
        @(negedge clk);
        idle();
        iss_en = 1'b1;
        iss_rd = 5'd4;
        @(negedge clk);
        idle();
        rs = {5'd31, 5'd4};
        #1;
        push("fill_rdata0", 32'h104);  chk(rdata[31:0]);
        push("fill_rdata1", 32'h11F);  chk(rdata[63:32]);
        push("fill_rbusy", 32'h1);     chk(32'(rbusy));
        push("fill_cnt", 32'h1);       chk(32'(busy_cnt));
        #2;
        reset_n = 1'b0;
        #1;
        push("mid_rst_rdata0", 32'h0); chk(rdata[31:0]);
        push("mid_rst_rdata1", 32'h0); chk(rdata[63:32]);
        push("mid_rst_rbusy", 32'h0);  chk(32'(rbusy));
        push("mid_rst_cnt", 32'h0);    chk(32'(busy_cnt));
        @(negedge clk);
        reset_n = 1'b1;

        // x0 ignores writes and issue marks.
        @(negedge clk);
        idle();
        wr0(5'd0, 32'hDEAD_BEEF, 1'b0);
        iss_en = 1'b1;
        iss_rd = 5'd0;
        #1;
        push("x0_rdata_byp", 32'h0);   chk(rdata[31:0]);
        push("x0_rbusy", 32'h0);       chk(32'(rbusy[0]));
        push("x0_stall", 32'h0);       chk(32'(iss_stall));
        @(posedge clk);
        #1;
        push("x0_rdata_after", 32'h0); chk(rdata[31:0]);
        push("x0_cnt", 32'h0);         chk(32'(busy_cnt));

        // Same-cycle bypass.
        @(negedge clk);
        idle();
        wr0(5'd5, 32'h1234, 1'b0);
        rs[4:0] = 5'd5;
        #1;
        push("byp_same", 32'h1234);    chk(rdata[31:0]);
        @(negedge clk);
        idle();
        rs[4:0] = 5'd5;
        #1;
        push("byp_next", 32'h1234);    chk(rdata[31:0]);

        // Two ports on the same rd: higher port wins.
        @(negedge clk);
        idle();
        wr_en = 2'b11;
        wr_rd = {5'd7, 5'd7};
        wdata = {32'hB, 32'hA};
        rs[4:0] = 5'd7;
        #1;
        push("prio_byp", 32'hB);       chk(rdata[31:0]);
        @(negedge clk);
        idle();
        wr_en = 2'b11;
        wr_rd = {5'd10, 5'd8};
        wdata = {32'hD, 32'hC};
        rs[4:0] = 5'd7;
        #1;
        push("prio_stored", 32'hB);    chk(rdata[31:0]);
        @(negedge clk);
        idle();
        rs = {5'd10, 5'd8};
        #1;
        push("dual_p0", 32'hC);        chk(rdata[31:0]);
        push("dual_p1", 32'hD);        chk(rdata[63:32]);

        // Scoreboard mark, WAW stall, release.
        @(negedge clk);
        idle();
        iss_en = 1'b1;
        iss_rd = 5'd3;
        rs[4:0] = 5'd3;
        #1;
        push("sb_stall0", 32'h0);      chk(32'(iss_stall));
        push("sb_rbusy_pre", 32'h0);   chk(32'(rbusy[0]));
        @(posedge clk);
        #1;
        push("sb_rbusy", 32'h1);       chk(32'(rbusy[0]));
        push("sb_cnt1", 32'h1);        chk(32'(busy_cnt));
        @(negedge clk);
        push("sb_waw_stall", 32'h1);   chk(32'(iss_stall));
        @(posedge clk);
        #1;
        push("sb_cnt_hold", 32'h1);    chk(32'(busy_cnt));
        @(negedge clk);
        idle();
        wr0(5'd3, 32'h33, 1'b1);
        rs[4:0] = 5'd3;
        #1;
        push("sb_clr_byp", 32'h0);     chk(32'(rbusy[0]));
        push("sb_clr_data", 32'h33);   chk(rdata[31:0]);
        push("sb_cnt_pre", 32'h1);     chk(32'(busy_cnt));
        @(posedge clk);
        #1;
        push("sb_cnt0", 32'h0);        chk(32'(busy_cnt));

        // Collision: clear and re-issue of a busy reg -> stall, ends not busy.
        @(negedge clk);
        idle();
        iss_en = 1'b1;
        iss_rd = 5'd9;
        @(negedge clk);
        idle();
        wr0(5'd9, 32'h99, 1'b1);
        iss_en = 1'b1;
        iss_rd = 5'd9;
        rs[4:0] = 5'd9;
        #1;
        push("col_stall", 32'h1);      chk(32'(iss_stall));
        @(posedge clk);
        #1;
        push("col_cnt0", 32'h0);       chk(32'(busy_cnt));
        @(negedge clk);
        idle();
        rs[4:0] = 5'd9;
        #1;
        push("col_rbusy0", 32'h0);     chk(32'(rbusy[0]));

        // Collision on a free reg: set wins over clear.
        @(negedge clk);
        idle();
        wr0(5'd9, 32'h98, 1'b1);
        iss_en = 1'b1;
        iss_rd = 5'd9;
        rs[4:0] = 5'd9;
        #1;
        push("set_stall", 32'h0);      chk(32'(iss_stall));
        @(posedge clk);
        #1;
        push("set_cnt1", 32'h1);       chk(32'(busy_cnt));
        @(negedge clk);
        idle();
        rs[4:0] = 5'd9;
        #1;
        push("set_rbusy", 32'h1);      chk(32'(rbusy[0]));
        push("set_data", 32'h98);      chk(rdata[31:0]);

        // wr_clr without wr_en has no effect.
        @(negedge clk);
        idle();
        wr_clr  = 2'b01;
        wr_rd   = {5'd0, 5'd9};
        rs[4:0] = 5'd9;
        #1;
        push("noen_rbusy", 32'h1);     chk(32'(rbusy[0]));
        @(posedge clk);
        #1;
        push("noen_cnt", 32'h1);       chk(32'(busy_cnt));

        @(negedge clk);
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
